data_mem_wait: RTL

//   Word-organised data memory with a multi-cycle request/ready handshake, sized

---
 rtl/data_mem_wait.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/data_mem_wait.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : data_mem_wait (with memory_pkg)
// Description : Word-organised data memory behind a request/ready handshake.
//               It has a programmable access latency, byte-enable stores and
//               registered load data.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

package memory_pkg;
    localparam int DATA_MEM_SIZE_BYTES = 2048;
endpackage

module data_mem_wait #(
    parameter int SIZE_BYTES = memory_pkg::DATA_MEM_SIZE_BYTES,
    parameter int LATENCY    = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_req_i,
    input  logic        write_enable_i,
    input  logic [3:0]  byte_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        ready_o
);

    localparam int c_IDX_HI = $clog2(SIZE_BYTES) - 1;
    localparam int c_IDX_W  = c_IDX_HI - 1;
    localparam int c_WORDS  = SIZE_BYTES / 4;

    // Each WAIT cycle adds one cycle of latency. The accept cycle and the DONE
    // cycle already account for two cycles, so the counter starts at LATENCY-2.
    // With LATENCY=1 the access happens on the accepting edge itself.
    localparam logic [3:0] c_CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
    localparam bit         c_FAST     = (LATENCY == 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [3:0]         r_cnt;
    logic               w_access;
    logic               r_ready;
    logic [31:0]        r_rdata;

    logic [c_IDX_W-1:0] r_idx;
    logic               r_we;
    logic [3:0]         r_be;
    logic [31:0]        r_wdata;

    logic [c_IDX_W-1:0] w_idx;
    logic               w_we;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic               w_unused_addr;

    logic [31:0] r_mem [c_WORDS] = '{default: 32'h0};

    // The address bits outside the word index are ignored, so accesses wrap.
    assign w_unused_addr = ^{addr_i[31:c_IDX_HI+1], addr_i[1:0]};

    // Use live inputs only when accessing straight from IDLE (LATENCY=1).
    // Otherwise use the operands latched at acceptance.
    always_comb begin
        w_idx   = r_idx;
        w_we    = r_we;
        w_be    = r_be;
        w_wdata = r_wdata;
        if (r_state == c_IDLE) begin
            w_idx   = addr_i[c_IDX_HI:2];
            w_we    = write_enable_i;
            w_be    = byte_enable_i;
            w_wdata = write_data_i;
        end
    end

    // Next state, and the strobe that marks the edge where the access happens.
    always_comb begin
        w_next_state = r_state;
        w_access     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (mem_req_i) begin
                    if (c_FAST) begin
                        w_access     = 1'b1;
                        w_next_state = c_DONE;
                    end else begin
                        w_next_state = c_WAIT;
                    end
                end
            end
            c_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_access     = 1'b1;
                    w_next_state = c_DONE;
                end
            end
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // State register, latency counter, operand latch, ready pulse and load data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
            r_ready <= 1'b0;
            r_rdata <= 32'h0;
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_be    <= 4'h0;
            r_wdata <= 32'h0;
        end else begin
            r_state <= w_next_state;
            r_ready <= w_access;
            if (r_state == c_IDLE && mem_req_i) begin
                r_idx   <= addr_i[c_IDX_HI:2];
                r_we    <= write_enable_i;
                r_be    <= byte_enable_i;
                r_wdata <= write_data_i;
                r_cnt   <= c_CNT_LOAD;
            end else if (r_state == c_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access && !w_we) begin
                r_rdata <= r_mem[w_idx];
            end
        end
    end

    // Byte-masked store. Gating with rst_ni stops a write while reset is held.
    always_ff @(posedge clk_i) begin
        if (rst_ni && w_access && w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    assign ready_o     = r_ready;
    assign read_data_o = r_rdata;

endmodule

`default_nettype wire
